// File: rtl/io_seg7_pkg.sv
// Shared constants and types for the io_seg7 scan controller family:
// hex glyph table (active-low, bit order g..a), blank pattern and FSM states.
package io_seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
  };

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/io_seg7_dec.sv
// Combinational hex nibble to active-low seven-segment lookup.
module io_seg7_dec
  import io_seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_GLYPH[nib];
  end

endmodule

// File: rtl/io_seg7_scan.sv
// Multiplexed common-anode seven-segment scan controller with frame-aligned
// double buffering. Optional leading-zero blanking: IO_SEG7_SCAN_LZB_EN.
module io_seg7_scan
  import io_seg7_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int ON_CYC  = 8,
  parameter int OFF_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  output logic                  pending,
  output logic                  frame,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     dig_n
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'((OFF_CYC > 0) ? OFF_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam scan_state_e      ST_INIT  = (OFF_CYC == 0) ? SHOW : BLANK;

  scan_state_e         state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                pending_q, pending_d;

  logic [6:0]          seg_n_q, seg_n_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                frame_q, frame_d;

  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                lz_blank_sel;
  logic [6:0]          dec_seg_n;

  // ---------------------------------------------------------------------------
  // Shadow / display double buffer. frame_q marks the last cycle of a frame,
  // so the edge that ends it is the only point where the display may change.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    disp_d      = disp_q;
    disp_dp_d   = disp_dp_q;
    pending_d   = pending_q;

    if (load) begin
      shadow_d    = data;
      shadow_dp_d = dp;
    end

    if (frame_q) begin
      disp_d    = load ? data : shadow_q;
      disp_dp_d = load ? dp   : shadow_dp_q;
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pending_q   <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      disp_q      <= disp_d;
      disp_dp_q   <= disp_dp_d;
      pending_q   <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == OFF_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == ON_LAST) begin
          state_d = (OFF_CYC == 0) ? SHOW : BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Digit select and decode. The mux reads the post-commit value so a digit
  // shown on the commit edge itself (OFF_CYC=0) is already the new frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    nib_sel = disp_d[4*int'(idx_q) +: 4];
    dp_sel  = disp_dp_d[idx_q];
  end

`ifdef IO_SEG7_SCAN_LZB_EN
  logic [DIGITS-1:0] lz_blank;
  logic              lz_run;

  // Walk from the top digit down; a run of zero nibbles blanks unless dp is lit.
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lz_run      = lz_run && (disp_d[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_run && !disp_dp_d[i];
    end
    lz_blank_sel = lz_blank[idx_q];
  end
`else
  always_comb begin
    lz_blank_sel = 1'b0;
  end
`endif

  io_seg7_dec u_dec (
    .nib   (nib_sel),
    .seg_n (dec_seg_n)
  );

  // Scan FSM: outputs, registered so dig_n and seg_n switch on the same edge.
  always_comb begin
    seg_n_d = SEG_OFF;
    dp_n_d  = 1'b1;
    dig_n_d = '1;
    frame_d = (state_q == SHOW) && (cnt_q == ON_LAST) && (idx_q == IDX_LAST);
    if (state_q == SHOW) begin
      dig_n_d = ~(DIGITS'(1) << idx_q);
      if (!lz_blank_sel) begin
        seg_n_d = dec_seg_n;
        dp_n_d  = ~dp_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n_q <= SEG_OFF;
      dp_n_q  <= 1'b1;
      dig_n_q <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      dig_n_q <= dig_n_d;
      frame_q <= frame_d;
    end
  end

  assign pending = pending_q;
  assign frame   = frame_q;
  assign seg_n   = seg_n_q;
  assign dp_n    = dp_n_q;
  assign dig_n   = dig_n_q;

endmodule

// File: tb/tb_io_seg7_scan.sv
// Self-checking bench for io_seg7_scan: directed spot table, randomized loads
// against a frame-arithmetic reference model, and an OFF_CYC=0 instance.
module tb_io_seg7_scan;

  localparam int D    = 4;
  localparam int ON   = 8;
  localparam int OFF  = 2;
  localparam int SLOT = OFF + ON;
  localparam int FR   = D * SLOT;

`ifdef IO_SEG7_SCAN_LZB_EN
  localparam bit         LZB = 1'b1;
  localparam logic [6:0] ZB  = 7'h7F;
`else
  localparam bit         LZB = 1'b0;
  localparam logic [6:0] ZB  = 7'h40;
`endif

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load;
  logic          load0;
  logic [15:0]   data;
  logic [3:0]    dp;

  logic          pending, frame, dp_n;
  logic [6:0]    seg_n;
  logic [3:0]    dig_n;
  logic          pending0, frame0, dp_n0;
  logic [6:0]    seg_n0;
  logic [3:0]    dig_n0;

  io_seg7_scan #(.DIGITS(D), .ON_CYC(ON), .OFF_CYC(OFF)) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .data(data), .dp(dp),
    .pending(pending), .frame(frame), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n)
  );

  io_seg7_scan #(.DIGITS(D), .ON_CYC(ON), .OFF_CYC(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .load(load0), .data(data), .dp(dp),
    .pending(pending0), .frame(frame0), .seg_n(seg_n0), .dp_n(dp_n0), .dig_n(dig_n0)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = -1;
  bit run         = 1'b0;

  // Reference model state: what the display holds and what is waiting.
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dpv, m_shdp;
  logic        m_pend;

  localparam logic [13:0] RST_VEC = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got{dig,seg,dp,pend,frm}=%h_%h_%b_%b_%b want=%h_%h_%b_%b_%b",
               name, cyc, act[13:10], act[9:3], act[2], act[1], act[0],
               exp[13:10], exp[9:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_disp = '0; m_shadow = '0; m_dpv = '0; m_shdp = '0; m_pend = 1'b0;
  endtask

  // Edge k: the frame ends on cycle k-1 when (k-1) is the last cycle of a frame.
  task automatic model_step(input int k, input logic l, input logic [15:0] dt, input logic [3:0] dv);
    bit commit;
    commit = (k >= 1) && (((k - 1) % FR) == FR - 1);
    if (commit) begin
      m_disp = l ? dt : m_shadow;
      m_dpv  = l ? dv : m_shdp;
      m_pend = 1'b0;
    end else if (l) begin
      m_pend = 1'b1;
    end
    if (l) begin
      m_shadow = dt;
      m_shdp   = dv;
    end
  endtask

  function automatic logic [13:0] model_exp(input int k);
    int pos, d, w;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic        dpn;
    logic [15:0] upper;
    bit          blanked;
    pos = k % FR;
    d   = pos / SLOT;
    w   = pos % SLOT;
    dig = 4'hF; seg = 7'h7F; dpn = 1'b1;
    if (w >= OFF) begin
      dig     = ~(4'b0001 << d);
      upper   = m_disp >> (4 * d);
      blanked = LZB && (d > 0) && (upper == 16'h0) && !m_dpv[d];
      if (!blanked) begin
        seg = GLYPH[upper[3:0]];
        dpn = ~m_dpv[d];
      end
    end
    return {dig, seg, dpn, m_pend, (pos == FR - 1)};
  endfunction

  function automatic logic [13:0] off0_exp(input int k);
    int d;
    d = (k / ON) % D;
    return {~(4'b0001 << d), (d == 0) ? 7'h40 : ZB, 1'b1, 1'b0, ((k % (D * ON)) == D * ON - 1)};
  endfunction

  // Per-cycle monitor: advance the model on each edge, compare #1 later.
  always @(posedge clk) begin
    logic        l_s;
    logic [15:0] d_s;
    logic [3:0]  p_s;
    l_s = load; d_s = data; p_s = dp;
    #1;
    if (run) begin
      cyc++;
      model_step(cyc, l_s, d_s, p_s);
      check("scan", {dig_n, seg_n, dp_n, pending, frame}, model_exp(cyc));
      check("off0", {dig_n0, seg_n0, dp_n0, pending0, frame0}, off0_exp(cyc));
      if (dig_n0 == 4'hF) check("off0_never_blank", {dig_n0, 10'h0}, {4'hE, 10'h0});
    end
  end

  typedef struct {
    int          cyc;
    logic [15:0] val;
    logic [3:0]  dpv;
  } load_t;

  typedef struct {
    int          cyc;
    logic [3:0]  dig;
    logic [6:0]  seg;
    logic        dpn;
    logic        pend;
    logic        frm;
  } spot_t;

  load_t loads [7];
  spot_t spots [34];

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cyc = -1;
    run = 1'b1;
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    return v;
  endfunction

  initial begin
    loads = '{
      '{5,   16'h1234, 4'h0}, '{55,  16'hFFFF, 4'h0}, '{90,  16'hAAAA, 4'h0},
      '{100, 16'hBBBB, 4'h0}, '{159, 16'hCCCC, 4'h0}, '{199, 16'h0050, 4'h0},
      '{239, 16'h0050, 4'h8}
    };
    spots = '{
      '{0,   4'hF, 7'h7F, 1, 0, 0}, '{1,   4'hF, 7'h7F, 1, 0, 0},
      '{2,   4'hE, 7'h40, 1, 0, 0}, '{5,   4'hE, 7'h40, 1, 0, 0},
      '{6,   4'hE, 7'h40, 1, 1, 0}, '{39,  4'h7, ZB,    1, 1, 1},
      '{40,  4'hF, 7'h7F, 1, 0, 0}, '{41,  4'hF, 7'h7F, 1, 0, 0},
      '{42,  4'hE, 7'h19, 1, 0, 0}, '{49,  4'hE, 7'h19, 1, 0, 0},
      '{52,  4'hD, 7'h30, 1, 0, 0}, '{55,  4'hD, 7'h30, 1, 0, 0},
      '{56,  4'hD, 7'h30, 1, 1, 0}, '{59,  4'hD, 7'h30, 1, 1, 0},
      '{62,  4'hB, 7'h24, 1, 1, 0}, '{72,  4'h7, 7'h79, 1, 1, 0},
      '{79,  4'h7, 7'h79, 1, 1, 1}, '{80,  4'hF, 7'h7F, 1, 0, 0},
      '{81,  4'hF, 7'h7F, 1, 0, 0}, '{82,  4'hE, 7'h0E, 1, 0, 0},
      '{91,  4'hF, 7'h7F, 1, 1, 0}, '{101, 4'hF, 7'h7F, 1, 1, 0},
      '{119, 4'h7, 7'h0E, 1, 1, 1}, '{122, 4'hE, 7'h03, 1, 0, 0},
      '{159, 4'h7, 7'h03, 1, 0, 1}, '{160, 4'hF, 7'h7F, 1, 0, 0},
      '{162, 4'hE, 7'h46, 1, 0, 0}, '{172, 4'hD, 7'h46, 1, 0, 0},
      '{202, 4'hE, 7'h40, 1, 0, 0}, '{212, 4'hD, 7'h12, 1, 0, 0},
      '{222, 4'hB, ZB,    1, 0, 0}, '{232, 4'h7, ZB,    1, 0, 0},
      '{262, 4'hB, ZB,    1, 0, 0}, '{272, 4'h7, 7'h40, 0, 0, 0}
    };

    reset_n = 1'b0; load = 1'b0; load0 = 1'b0; data = 16'h0; dp = 4'h0;
    repeat (3) @(negedge clk);
    check("reset", {dig_n, seg_n, dp_n, pending, frame}, RST_VEC);
    check("reset_off0", {dig_n0, seg_n0, dp_n0, pending0, frame0}, RST_VEC);
    release_reset();

    // Directed frames; garbage on data/dp whenever load is low.
    for (int n = 0; n <= 280; n++) begin
      @(negedge clk);
      if (cyc != n) check("cycle_align", 14'(cyc), 14'(n));
      foreach (spots[s])
        if (spots[s].cyc == n)
          check("spot", {dig_n, seg_n, dp_n, pending, frame},
                {spots[s].dig, spots[s].seg, spots[s].dpn, spots[s].pend, spots[s].frm});
      load = 1'b0; data = 16'hDEAD; dp = 4'hF;
      foreach (loads[j])
        if (loads[j].cyc == n) begin
          load = 1'b1; data = loads[j].val; dp = loads[j].dpv;
        end
    end

    // Random loads, model compares every cycle.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      data = rand_data();
      dp   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
    end

    // Pending load, then asynchronous reset in the middle of a SHOW slot.
    @(negedge clk);
    load = 1'b0;
    for (int g = 0; g < FR && ((cyc % SLOT) != 3); g++) @(negedge clk);
    load = 1'b1; data = 16'h9876; dp = 4'h5;
    @(negedge clk);
    load = 1'b0;
    check("pre_rst_pending", {13'h0, pending}, 14'h1);
    #2;
    run = 1'b0;
    reset_n = 1'b0;
    #1;
    check("mid_rst", {dig_n, seg_n, dp_n, pending, frame}, RST_VEC);
    check("mid_rst_off0", {dig_n0, seg_n0, dp_n0, pending0, frame0}, RST_VEC);
    repeat (2) @(negedge clk);
    release_reset();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 2) check("post_rst_digit0", {dig_n, seg_n, dp_n, pending, frame},
                        {4'hE, 7'h40, 1'b1, 1'b0, 1'b0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
